sipo_buffer: RTL and testbench

Serial-in parallel-out collector, the receive-side counterpart of the PISO word serializer. Accepts one WIDTH-bit word per cycle and assembles DEPTH words into a single WIDTH*DEPTH-bit vector for the aggregation datapath. A vector serialized by the PISO and fed word-by-word into this block reappears bit-identical at `dout`. Optional ping-pong banking lets filling continue while a completed vector waits for consumption.

---
 rtl/sipo_buffer_if.sv | 32 +++
 rtl/sipo_buffer.sv | 147 ++++++++++++++
 tb/tb_sipo_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_buffer_if.sv
// sipo_buffer_if: bus bundle for the serial-in parallel-out collector.
//   din/we    : serial word and write enable (master -> collector)
//   clear     : synchronous flush (master -> collector)
//   re        : consume the presented vector (master -> collector)
//   full      : no free slot, writes dropped (collector -> master)
//   dout/valid: assembled vector, zero while valid=0 (collector -> master)
//   count     : words held in the fill bank, 0..DEPTH (collector -> master)
interface sipo_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       din;
  logic                   we;
  logic                   full;
  logic                   clear;
  logic [WIDTH*DEPTH-1:0] dout;
  logic                   valid;
  logic                   re;
  logic [CntW-1:0]        count;

  modport master (
    output din, we, clear, re,
    input  full, dout, valid, count
  );

  modport slave (
    input  din, we, clear, re,
    output full, dout, valid, count
  );
endinterface

// File: rtl/sipo_buffer.sv
// sipo_buffer: collects DEPTH serial WIDTH-bit words into one WIDTH*DEPTH-bit vector.
// The first accepted word lands in the MSB slice of dout.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : sipo_buffer_if.slave (din, we, clear, re in; full, dout, valid, count out)
// Optional feature: define SIPO_PINGPONG_EN for a second (output) bank so filling
// continues while a completed vector waits to be consumed. Default is a single bank
// where full equals valid.
module sipo_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic          clk,
  input logic          arst_n,
  sipo_buffer_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam int unsigned     IdxW    = $clog2(DEPTH);
  localparam int unsigned     VecW    = WIDTH * DEPTH;
  localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);

  typedef enum logic {StFilling, StDone} fill_st_e;

  fill_st_e        st_q, st_d;
  logic [CntW-1:0] count_q, count_d;
  logic [VecW-1:0] fill_q, fill_d;
  logic [VecW-1:0] fill_wr;
  logic [IdxW-1:0] slot;
  logic            wr_acc;
  logic            last_wr;

  // count never exceeds DEPTH-1 while filling, so the low bits address the slot.
  assign slot    = count_q[IdxW-1:0];
  assign wr_acc  = bus.we && (st_q == StFilling);
  assign last_wr = wr_acc && (count_q == LastIdx);

  // Fill bank as it looks once din is written into the current slot.
  always_comb begin
    fill_wr = fill_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (slot == IdxW'(k)) fill_wr[VecW-1-WIDTH*k -: WIDTH] = bus.din;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q    <= StFilling;
      count_q <= '0;
      fill_q  <= '0;
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.full  = (st_q == StDone);
  assign bus.count = count_q;

`ifndef SIPO_PINGPONG_EN
  logic re_eff;

  assign re_eff = bus.re && (st_q == StDone);

  // Release takes priority over a same-cycle write, so that write is dropped.
  always_comb begin
    st_d    = st_q;
    count_d = count_q;
    fill_d  = fill_q;
    if (bus.clear) begin
      st_d    = StFilling;
      count_d = '0;
      fill_d  = '0;
    end else if (re_eff) begin
      st_d    = StFilling;
      count_d = '0;
    end else if (wr_acc) begin
      fill_d  = fill_wr;
      count_d = count_q + CntW'(1);
      if (last_wr) st_d = StDone;
    end
  end

  assign bus.valid = (st_q == StDone);
  assign bus.dout  = bus.valid ? fill_q : '0;
`else
  logic            valid_q, valid_d;
  logic [VecW-1:0] out_q, out_d;
  logic            re_eff;
  logic            out_free;

  assign re_eff   = bus.re && valid_q;
  assign out_free = !valid_q || re_eff;

  always_comb begin
    st_d    = st_q;
    count_d = count_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (bus.clear) begin
      st_d    = StFilling;
      count_d = '0;
      fill_d  = '0;
      valid_d = 1'b0;
      out_d   = '0;
    end else if (st_q == StDone) begin
      // Completed fill bank waits for the output bank; swap on release.
      if (re_eff) begin
        out_d   = fill_q;
        valid_d = 1'b1;
        st_d    = StFilling;
        count_d = '0;
      end
    end else begin
      if (re_eff) valid_d = 1'b0;
      if (wr_acc) begin
        fill_d  = fill_wr;
        count_d = count_q + CntW'(1);
        if (last_wr) begin
          if (out_free) begin
            // Swap straight away: fill restarts next cycle with no bubble.
            out_d   = fill_wr;
            valid_d = 1'b1;
            count_d = '0;
          end else begin
            st_d = StDone;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.dout  = valid_q ? out_q : '0;
`endif
endmodule

// File: tb/tb_sipo_buffer.sv
// tb_sipo_buffer: scoreboard bench for sipo_buffer. Stimulus pushes each expected
// vector when it issues the completing write; a monitor pops and compares whenever
// a new vector appears on dout. Status outputs are checked directly after edges.
module tb_sipo_buffer;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned VW = W * D;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  sipo_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sipo_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [VW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, return 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [W-1:0] din, input logic re, input logic clr);
    bus.we    = we;
    bus.din   = din;
    bus.re    = re;
    bus.clear = clr;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.din   = '0;
    bus.re    = 1'b0;
    bus.clear = 1'b0;
  endtask

  // Monitor: a new vector is on dout when valid rises or stays up after a consume.
  initial begin
    logic pv, pr;
    logic [VW-1:0] e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid && (!pv || pr)) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_vector: got %0h expected none", bus.dout);
        end else begin
          e = exp_q.pop_front();
          chk("vector", bus.dout, e);
        end
      end
      pv = bus.valid;
      pr = bus.re && bus.valid;
    end
  end

  initial begin
    logic [VW-1:0] piso;
    bus.we = 1'b0; bus.din = '0; bus.re = 1'b0; bus.clear = 1'b0;

    // Reset state
    #12;
    chk("rst_full", bus.full, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_count", bus.count, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // 16 writes 0x00..0x0F
    exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    for (int k = 0; k < 16; k++) cyc(1'b1, W'(k), 1'b0, 1'b0);
    chk("t1_valid", bus.valid, 1);
`ifndef SIPO_PINGPONG_EN
    chk("t1_full", bus.full, 1);
    chk("t1_count", bus.count, 16);
    // Write while full is dropped
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("drop_count", bus.count, 16);
    chk("drop_dout", bus.dout, 128'h000102030405060708090A0B0C0D0E0F);
`else
    chk("t1_full", bus.full, 0);
    chk("t1_count", bus.count, 0);
`endif

    // Consume with simultaneous write of 0xAA
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t2_valid", bus.valid, 0);
    chk("t2_dout", bus.dout, 0);
`ifndef SIPO_PINGPONG_EN
    chk("t2_count", bus.count, 0);
`else
    chk("t2_count", bus.count, 1);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_clear_count", bus.count, 0);

    // Round trip through a PISO model (MSB word shifted out first)
    piso = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp_q.push_back(piso);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, piso[VW-1 -: W], 1'b0, 1'b0);
      piso = piso << W;
    end
    chk("rt_valid", bus.valid, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rt_release", bus.valid, 0);

    // Partial fill, re without valid, then clear with a same-cycle write
    for (int k = 0; k < 3; k++) cyc(1'b1, W'(8'h11 + k), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("re_no_valid_count", bus.count, 3);
    for (int k = 3; k < 7; k++) cyc(1'b1, W'(8'h11 + k), 1'b0, 1'b0);
    chk("pre_clear_count", bus.count, 7);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("clear_count", bus.count, 0);
    chk("clear_valid", bus.valid, 0);
    exp_q.push_back({VW{1'b1}});
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ff_valid", bus.valid, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef SIPO_PINGPONG_EN
    // 32 back-to-back writes with the output never consumed
    exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
    for (int k = 0; k < 16; k++) cyc(1'b1, W'(k), 1'b0, 1'b0);
    chk("pp_first_valid", bus.valid, 1);
    chk("pp_first_count", bus.count, 0);
    for (int k = 16; k < 32; k++) cyc(1'b1, W'(k), 1'b0, 1'b0);
    chk("pp_full", bus.full, 1);
    chk("pp_count16", bus.count, 16);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_swap_valid", bus.valid, 1);
    chk("pp_swap_full", bus.full, 0);
    chk("pp_swap_count", bus.count, 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_drain_valid", bus.valid, 0);
`endif

    // Async reset with a vector presented and a partial fill behind it
    exp_q.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    for (int k = 0; k < 16; k++) cyc(1'b1, W'(8'hA0 + k), 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b1, W'(8'hC0 + k), 1'b0, 1'b0);
`ifndef SIPO_PINGPONG_EN
    chk("pre_rst_count", bus.count, 16);
`else
    chk("pre_rst_count", bus.count, 9);
`endif
    chk("pre_rst_valid", bus.valid, 1);
    #1;
    arst_n = 1'b0;
    #1;
    chk("arst_valid", bus.valid, 0);
    chk("arst_full", bus.full, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_count", bus.count, 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 15; k++) cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("recov15_valid", bus.valid, 0);
    chk("recov15_count", bus.count, 15);
    exp_q.push_back({D{8'h3C}});
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("recov16_valid", bus.valid, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("queue_drained", VW'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
